// File: rtl/instruction_replay_buffer.sv
// Instruction replay buffer: captures one program into on-chip RAM, then streams it
// back num_passes times (0 = forever) on a valid/ready interface.
module instruction_replay_buffer #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int MAX_INSTRUCTIONS  = 512,
    parameter int PASS_WIDTH        = 8,
    localparam int ADDR_WIDTH       = (MAX_INSTRUCTIONS > 1) ? $clog2(MAX_INSTRUCTIONS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [PASS_WIDTH-1:0]        num_passes,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         wr_last,
    input  logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [INSTRUCTION_WIDTH-1:0] rd_data,
    output logic                         rd_last,
    output logic [PASS_WIDTH-1:0]        rd_pass_index,
    output logic [ADDR_WIDTH:0]          instr_count,
    output logic                         done,
    output logic                         overflow
);

    typedef enum logic [1:0] {
        S_FILL,
        S_REPLAY,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LAST_SLOT = (ADDR_WIDTH + 1)'(MAX_INSTRUCTIONS - 1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0] PASS_ONE  = PASS_WIDTH'(1);

    state_t state, state_next;

    logic [INSTRUCTION_WIDTH-1:0] mem [MAX_INSTRUCTIONS];

    logic [ADDR_WIDTH:0]          count;
    logic [PASS_WIDTH-1:0]        passes_q;
    logic [PASS_WIDTH-1:0]        issue_pass;
    logic [PASS_WIDTH-1:0]        pass_idx;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic                         overflow_q;

    logic                         wr_accept;
    logic                         depth_hit;
    logic                         fill_term;
    logic                         issue;
    logic                         issue_last;
    logic                         issue_stop;
    logic                         out_fire;
    logic                         final_beat;

    logic                         ram_q_valid;
    logic                         ram_q_last;
    logic [INSTRUCTION_WIDTH-1:0] ram_q_data;
    logic                         ram_q_taken;

    logic                         out_valid, out_valid_n;
    logic                         out_last, out_last_n;
    logic [INSTRUCTION_WIDTH-1:0] out_data, out_data_n;
    logic                         skid_valid, skid_valid_n;
    logic                         skid_last, skid_last_n;
    logic [INSTRUCTION_WIDTH-1:0] skid_data, skid_data_n;

    assign wr_accept  = (state == S_FILL) && wr_valid && !clear;
    assign depth_hit  = (count == LAST_SLOT);
    assign fill_term  = wr_accept && (wr_last || depth_hit);

    // Reads are issued only while the skid slot is empty, so the address never waits
    // on rd_ready; the one word already in the RAM register always has somewhere to go.
    assign issue_stop = (passes_q != '0) && (issue_pass == passes_q);
    assign issue      = (state == S_REPLAY) && !skid_valid && !issue_stop && !clear;
    assign issue_last = ({1'b0, rd_addr} == (count - COUNT_ONE));

    assign out_fire   = out_valid && rd_ready;
    assign final_beat = out_fire && out_last && (passes_q != '0)
                        && ((pass_idx + PASS_ONE) == passes_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL:   if (fill_term)  state_next = S_REPLAY;
            S_REPLAY: if (final_beat) state_next = S_DONE;
            S_DONE:   state_next = S_DONE;
            default:  state_next = S_FILL;
        endcase
        if (clear) begin
            state_next = S_FILL;
        end
    end

    // Output register is refilled from the skid first, then straight from the RAM register.
    always_comb begin
        out_valid_n  = out_valid;
        out_last_n   = out_last;
        out_data_n   = out_data;
        skid_valid_n = skid_valid;
        skid_last_n  = skid_last;
        skid_data_n  = skid_data;
        ram_q_taken  = 1'b0;
        if (!out_valid || out_fire) begin
            if (skid_valid) begin
                out_valid_n  = 1'b1;
                out_last_n   = skid_last;
                out_data_n   = skid_data;
                skid_valid_n = ram_q_valid;
                skid_last_n  = ram_q_last;
                skid_data_n  = ram_q_data;
                ram_q_taken  = ram_q_valid;
            end else begin
                out_valid_n  = ram_q_valid;
                if (ram_q_valid) begin
                    out_last_n = ram_q_last;
                    out_data_n = ram_q_data;
                end
                ram_q_taken  = ram_q_valid;
            end
        end else if (!skid_valid) begin
            skid_valid_n = ram_q_valid;
            skid_last_n  = ram_q_last;
            skid_data_n  = ram_q_data;
            ram_q_taken  = ram_q_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            passes_q    <= '0;
            issue_pass  <= '0;
            pass_idx    <= '0;
            rd_addr     <= '0;
            overflow_q  <= 1'b0;
            ram_q_valid <= 1'b0;
            ram_q_last  <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            skid_valid  <= 1'b0;
            skid_last   <= 1'b0;
            skid_data   <= '0;
        end else if (clear) begin
            count       <= '0;
            issue_pass  <= '0;
            pass_idx    <= '0;
            rd_addr     <= '0;
            overflow_q  <= 1'b0;
            ram_q_valid <= 1'b0;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
        end else begin
            if (wr_accept) begin
                count <= count + COUNT_ONE;
            end
            if (fill_term) begin
                passes_q   <= num_passes;
                overflow_q <= overflow_q | (depth_hit && !wr_last);
            end
            if (issue) begin
                ram_q_last <= issue_last;
                if (issue_last) begin
                    rd_addr    <= '0;
                    issue_pass <= issue_pass + PASS_ONE;
                end else begin
                    rd_addr <= rd_addr + ADDR_ONE;
                end
            end
            ram_q_valid <= issue || (ram_q_valid && !ram_q_taken);
            out_valid   <= out_valid_n;
            out_last    <= out_last_n;
            out_data    <= out_data_n;
            skid_valid  <= skid_valid_n;
            skid_last   <= skid_last_n;
            skid_data   <= skid_data_n;
            if (out_fire && out_last) begin
                pass_idx <= pass_idx + PASS_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[count[ADDR_WIDTH-1:0]] <= wr_data;
        end
        if (issue) begin
            ram_q_data <= mem[rd_addr];
        end
    end

    assign wr_ready      = (state == S_FILL);
    assign rd_valid      = out_valid;
    assign rd_data       = out_data;
    assign rd_last       = out_last;
    assign rd_pass_index = pass_idx;
    assign instr_count   = count;
    assign done          = (state == S_DONE);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_instruction_replay_buffer.sv
// Directed bench for instruction_replay_buffer built with an 8-deep store so the
// depth limit is reachable; expected streams are generated from the loaded words.
module tb_instruction_replay_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [7:0]  num_passes;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_last;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic [7:0]  rd_pass_index;
    logic [3:0]  instr_count;
    logic        done;
    logic        overflow;

    int checks = 0;
    int fails  = 0;

    instruction_replay_buffer #(
        .INSTRUCTION_WIDTH(16),
        .MAX_INSTRUCTIONS(8),
        .PASS_WIDTH(8)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .num_passes(num_passes),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_last(wr_last),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .rd_last(rd_last),
        .rd_pass_index(rd_pass_index),
        .instr_count(instr_count),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] data, input logic last);
        wr_valid = 1'b1;
        wr_data  = data;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Consume n beats of a len-word program whose words are base, base+1, ...
    task automatic replay(input int n, input int len, input logic [15:0] base, input bit stall);
        logic [15:0] pat;
        int  idx;
        int  cyc;
        bit  seen;
        bit  prev_stalled;
        pat = 16'b1001_0110_0011_1001;
        idx = 0;
        cyc = 0;
        seen = 1'b0;
        prev_stalled = 1'b0;
        while (idx < n && cyc < n * 4 + 20) begin
            rd_ready = stall ? pat[cyc % 16] : 1'b1;
            if (prev_stalled) chk("stall_hold_valid", rd_valid, 1);
            if (seen && !stall) chk("gapless", rd_valid, 1);
            if (rd_valid) begin
                seen = 1'b1;
                chk("rd_data", rd_data, base + (idx % len));
                chk("rd_last", rd_last, (idx % len) == (len - 1));
                chk("rd_pass_index", rd_pass_index, (idx / len) % 256);
                if (rd_ready) idx++;
            end
            prev_stalled = rd_valid && !rd_ready;
            tick();
            cyc++;
        end
        chk("beat_count", idx, n);
        rd_ready = 1'b0;
    endtask

    initial begin
        int acc;
        reset      = 1'b1;
        clear      = 1'b0;
        num_passes = 8'd0;
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        wr_data    = 16'h0000;
        rd_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pass", rd_pass_index, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);

        // Five words, three passes, consumer always ready.
        num_passes = 8'd3;
        rd_ready   = 1'b1;
        for (int i = 1; i <= 5; i++) write_word(16'(i), i == 5);
        chk("t1_wr_ready_off", wr_ready, 0);
        chk("t1_count", instr_count, 5);
        chk("t1_lat0", rd_valid, 0);
        tick();
        chk("t1_lat1", rd_valid, 0);
        tick();
        chk("t1_lat2", rd_valid, 1);
        replay(15, 5, 16'h0001, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_valid_after", rd_valid, 0);
        chk("t1_pass_final", rd_pass_index, 3);
        chk("t1_overflow", overflow, 0);

        // Same program with an irregular consumer.
        do_clear();
        chk("t2_clr_wr_ready", wr_ready, 1);
        chk("t2_clr_done", done, 0);
        chk("t2_clr_count", instr_count, 0);
        num_passes = 8'd3;
        for (int i = 1; i <= 5; i++) write_word(16'(i), i == 5);
        replay(15, 5, 16'h0001, 1'b1);
        chk("t2_done", done, 1);
        chk("t2_valid_after", rd_valid, 0);

        // Depth limit: ten beats offered, never marked last.
        do_clear();
        num_passes = 8'd1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'h0010 + 16'(i);
            wr_last  = 1'b0;
            if (wr_ready) acc++;
            tick();
        end
        wr_valid = 1'b0;
        chk("t3_accepted", acc, 8);
        chk("t3_wr_ready", wr_ready, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_count", instr_count, 8);
        replay(8, 8, 16'h0010, 1'b0);
        chk("t3_done", done, 1);
        chk("t3_overflow_sticky", overflow, 1);

        // Single word, infinite passes, pass index wraps.
        do_clear();
        chk("t4_overflow_cleared", overflow, 0);
        num_passes = 8'd0;
        write_word(16'hBEEF, 1'b1);
        replay(300, 1, 16'hBEEF, 1'b0);
        chk("t4_done", done, 0);
        chk("t4_valid", rd_valid, 1);
        chk("t4_pass", rd_pass_index, 44);

        // Clear while stalled in the second pass, then reload.
        do_clear();
        num_passes = 8'd3;
        for (int i = 0; i < 5; i++) write_word(16'h0021 + 16'(i), i == 4);
        replay(7, 5, 16'h0021, 1'b0);
        tick();
        tick();
        chk("t5_stall_valid", rd_valid, 1);
        chk("t5_stall_data", rd_data, 16'h0023);
        chk("t5_stall_pass", rd_pass_index, 1);
        chk("t5_stall_last", rd_last, 0);
        do_clear();
        chk("t5_clr_valid", rd_valid, 0);
        chk("t5_clr_wr_ready", wr_ready, 1);
        chk("t5_clr_count", instr_count, 0);
        chk("t5_clr_pass", rd_pass_index, 0);
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        wr_valid = 1'b0;
        chk("t5_clr_write_ignored", instr_count, 0);
        num_passes = 8'd2;
        for (int i = 0; i < 3; i++) write_word(16'h0031 + 16'(i), i == 2);
        replay(6, 3, 16'h0031, 1'b0);
        chk("t5_done", done, 1);

        // Asynchronous reset in the middle of replay.
        do_clear();
        num_passes = 8'd2;
        for (int i = 0; i < 4; i++) write_word(16'h0041 + 16'(i), i == 3);
        replay(2, 4, 16'h0041, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_wr_ready", wr_ready, 1);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_rd_last", rd_last, 0);
        chk("t6_pass", rd_pass_index, 0);
        chk("t6_count", instr_count, 0);
        chk("t6_done", done, 0);
        chk("t6_overflow", overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        num_passes = 8'd1;
        write_word(16'h0051, 1'b0);
        write_word(16'h0052, 1'b1);
        chk("t6_count_reload", instr_count, 2);
        replay(2, 2, 16'h0051, 1'b0);
        chk("t6_done_reload", done, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
